// File: rtl/bit_align_scheduler.sv
// Calibration sequencer for a bank of bitAligner lanes: arms each selected lane's auto mode,
// waits for align_done, retries on error/timeout, and records lock status and latch polarity.
module bit_align_scheduler #(
    parameter int NLANE     = 4,
    parameter int SETTLE    = 16,
    parameter int TIMEOUT   = 1023,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [NLANE-1:0] lane_mask,
    input  logic [NLANE-1:0] lane_align_done,
    input  logic [NLANE-1:0] lane_align_error,
    input  logic [NLANE-1:0] lane_latch_edge,
    output logic [NLANE-1:0] auto_mode,
    output logic [NLANE-1:0] manual_latch,
    output logic             busy,
    output logic             done,
    output logic [NLANE-1:0] lane_locked,
    output logic [NLANE-1:0] lane_failed
);
    localparam int IDX_W = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NLANE - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);
    localparam logic [15:0]      TMO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        ARM    = 3'd2,
        WAIT   = 3'd3,
        CHECK  = 3'd4,
        DROP   = 3'd5,
        NEXT   = 3'd6,
        FINISH = 3'd7
    } state_t;

    state_t           state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [3:0]       retry_r, retry_s;
    logic [SET_W-1:0] settle_r, settle_s;
    logic [15:0]      tmo_r, tmo_s;
    logic [1:0]       drop_r, drop_s;
    logic [NLANE-1:0] mask_r, mask_s;
    logic [NLANE-1:0] auto_mode_r, auto_mode_s;
    logic [NLANE-1:0] manual_latch_r, manual_latch_s;
    logic [NLANE-1:0] lane_locked_r, lane_locked_s;
    logic [NLANE-1:0] lane_failed_r, lane_failed_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             fail_s;

    // Next-state, counter and status computation; outputs derive from the next state so they register in step.
    always_comb begin
        state_s        = state_r;
        idx_s          = idx_r;
        retry_s        = retry_r;
        settle_s       = settle_r;
        tmo_s          = tmo_r;
        drop_s         = drop_r;
        mask_s         = mask_r;
        manual_latch_s = manual_latch_r;
        lane_locked_s  = lane_locked_r;
        lane_failed_s  = lane_failed_r;
        fail_s         = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    mask_s         = lane_mask;
                    idx_s          = {IDX_W{1'b0}};
                    retry_s        = 4'd0;
                    manual_latch_s = {NLANE{1'b0}};
                    lane_locked_s  = {NLANE{1'b0}};
                    lane_failed_s  = {NLANE{1'b0}};
                    state_s        = SELECT;
                end else begin
                    state_s = IDLE;
                end
            end
            SELECT: begin
                if (mask_r[idx_r]) begin
                    settle_s = SETTLE_LOAD;
                    state_s  = ARM;
                end else begin
                    state_s = NEXT;
                end
            end
            ARM: begin
                if (settle_r == {SET_W{1'b0}}) begin
                    tmo_s   = 16'd0;
                    state_s = WAIT;
                end else begin
                    settle_s = settle_r - SET_W'(1);
                end
            end
            WAIT: begin
                // done wins over a timeout landing in the same cycle
                if (lane_align_done[idx_r]) begin
                    state_s = CHECK;
                end else if (tmo_r == TMO_LAST) begin
                    fail_s = 1'b1;
                end else if (tmo_r != 16'hFFFF) begin
                    tmo_s = tmo_r + 16'd1;
                end else begin
                    tmo_s = tmo_r;
                end
            end
            CHECK: begin
                if (!lane_align_error[idx_r]) begin
                    lane_locked_s[idx_r]  = 1'b1;
                    manual_latch_s[idx_r] = lane_latch_edge[idx_r];
                    state_s               = NEXT;
                end else begin
                    fail_s = 1'b1;
                end
            end
            DROP: begin
                if (drop_r == 2'd0) begin
                    settle_s = SETTLE_LOAD;
                    state_s  = ARM;
                end else begin
                    drop_s = drop_r - 2'd1;
                end
            end
            NEXT: begin
                if (idx_r == LAST_IDX) begin
                    state_s = FINISH;
                end else begin
                    idx_s   = idx_r + IDX_W'(1);
                    retry_s = 4'd0;
                    state_s = SELECT;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (fail_s) begin
            if (retry_r < RETRY_MAX) begin
                retry_s = retry_r + 4'd1;
                drop_s  = 2'd3;
                state_s = DROP;
            end else begin
                lane_failed_s[idx_r]  = 1'b1;
                manual_latch_s[idx_r] = 1'b0;
                state_s               = NEXT;
            end
        end else begin
            drop_s = drop_s;
        end

        if (state_s == ARM || state_s == WAIT || state_s == CHECK) begin
            auto_mode_s = NLANE'(1'b1) << idx_s;
        end else begin
            auto_mode_s = {NLANE{1'b0}};
        end
        busy_s = (state_s != IDLE);
        done_s = (state_s == FINISH);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r        <= IDLE;
            idx_r          <= {IDX_W{1'b0}};
            retry_r        <= 4'd0;
            settle_r       <= {SET_W{1'b0}};
            tmo_r          <= 16'd0;
            drop_r         <= 2'd0;
            mask_r         <= {NLANE{1'b0}};
            auto_mode_r    <= {NLANE{1'b0}};
            manual_latch_r <= {NLANE{1'b0}};
            lane_locked_r  <= {NLANE{1'b0}};
            lane_failed_r  <= {NLANE{1'b0}};
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            idx_r          <= idx_s;
            retry_r        <= retry_s;
            settle_r       <= settle_s;
            tmo_r          <= tmo_s;
            drop_r         <= drop_s;
            mask_r         <= mask_s;
            auto_mode_r    <= auto_mode_s;
            manual_latch_r <= manual_latch_s;
            lane_locked_r  <= lane_locked_s;
            lane_failed_r  <= lane_failed_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
        end
    end

    assign auto_mode    = auto_mode_r;
    assign manual_latch = manual_latch_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign lane_locked  = lane_locked_r;
    assign lane_failed  = lane_failed_r;

endmodule
